arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter SW, default $clog2(N), select/grant index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  N  per-channel valid.
REQ-007 in_data  input  N*WIDTH  channel k in bits [k*WIDTH +: WIDTH].
REQ-008 in_ready  output  N  per-channel accept, combinational.
REQ-009 out_valid  output  1  registered output valid.
REQ-010 out_data  output  WIDTH  registered output data.
REQ-011 out_sel  output  SW  index of channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 SHALL hold one output register slot; slot free when out_valid=0 or (out_valid && out_ready).
REQ-014 SHALL grant at most one channel per cycle, only when the slot is free; in_ready[k]=1 only for the granted k. A transfer occurs on in_valid[k] && in_ready[k].
REQ-015 SHALL arbitrate round-robin: a pointer ptr (SW bits) gives the highest-priority channel, priority descending ptr, ptr+1, ... wrapping mod N.
REQ-016 SHALL, after a transfer from channel k, set ptr = (k+1) mod N; ptr unchanged on cycles with no transfer.
REQ-017 SHALL load out_data=in_data[k], out_sel=k, out_valid=1 on the edge after transfer; latency 1 cycle.
REQ-018 SHALL clear out_valid when out_ready=1 with out_valid=1 and no new transfer that cycle.
REQ-019 SHALL sustain 1 transfer/cycle when out_ready held 1 (consume and refill same cycle).
REQ-020 SHALL hold out_data/out_sel stable while out_valid=1 && out_ready=0.
REQ-021 SHALL assert no in_ready when no in_valid asserted; no transfer, ptr unchanged.
REQ-022 SHALL not depend on in_data of non-granted channels; in_valid may drop without transfer while not granted.
REQ-023 SHALL, with N not a power of 2, never produce ptr or out_sel >= N (wrap from N-1 to 0).

Reset
REQ-024 On clk edge with rst_n=0: out_valid=0, out_data=0, out_sel=0, ptr=0, lock state cleared; in_ready=0 during reset.
REQ-025 Reset mid-operation SHALL discard the held beat; no transfer counted for the reset cycle.

Configuration
REQ-026 Macro ARB_MUX_LOCK_EN SHALL enable packet lock: adds input in_last (N bits, per-channel last-beat flag) and output out_last (1 bit, registered with out_data).
REQ-027 With ARB_MUX_LOCK_EN: after a transfer from k with in_last[k]=0, grant SHALL remain locked to k (other channels in_ready=0) until a transfer from k with in_last[k]=1; ptr advances only on the last beat.
REQ-028 Without ARB_MUX_LOCK_EN: no in_last/out_last ports; every beat independently arbitrated per REQ-015/016.

Verification
REQ-029 N=4, after reset, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid=1 from cycle 2.
REQ-030 in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=0 -> out_valid=1, out_data=32'hDEADBEEF held, in_ready=0 for all channels until out_ready=1.
REQ-031 ptr=3, in_valid=4'b1001 -> channel 3 granted, then channel 0 (wrap), ptr=1.
REQ-032 N=3, all valid, out_ready=1 for 7 cycles -> out_sel 0,1,2,0,1,2,0; never 3.
REQ-033 LOCK_EN: ch1 sends 3 beats (in_last on 3rd) while ch0,ch2 valid -> out_sel 1,1,1 then 2.
REQ-034 Reset asserted while out_valid=1 -> next cycle out_valid=0, ptr=0, out_sel=0.

Source files
------------

// File: rtl/arb_mux.sv
// Round-robin N:1 arbiter feeding a single registered output slot.
// Optional packet lock (in_last/out_last) is enabled with `define ARB_MUX_LOCK_EN.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SW-1:0]    out_sel_q;
  logic [SW-1:0]    ptr_q;
  logic [SW-1:0]    ptr_d;

  logic             slot_free;
  logic [N-1:0]     cand;
  logic             gnt_found;
  logic [SW-1:0]    gnt_idx;
  logic             xfer;
  int unsigned      scan_idx;
  logic [SW-1:0]    scan_sw;

`ifdef ARB_MUX_LOCK_EN
  logic             lock_q;
  logic [SW-1:0]    lock_idx_q;
  logic             out_last_q;
`endif

  // The slot can be refilled in the same cycle the downstream consumes it.
  assign slot_free = !out_valid_q || out_ready;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cand      = in_valid;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    scan_sw   = '0;
`ifdef ARB_MUX_LOCK_EN
    if (lock_q) begin
      cand             = '0;
      cand[lock_idx_q] = in_valid[lock_idx_q];
    end
`endif
    for (int i = 0; i < N; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      scan_sw = SW'(scan_idx);
      if (!gnt_found && cand[scan_sw]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sw;
      end
    end
  end

  assign in_ready = (rst_n && slot_free && gnt_found) ? (N'(1) << gnt_idx) : '0;
  assign xfer     = |(in_valid & in_ready);
  assign ptr_d    = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        out_sel_q   <= gnt_idx;
`ifdef ARB_MUX_LOCK_EN
        out_last_q  <= in_last[gnt_idx];
        // Mid-packet beats keep the grant and hold the pointer.
        if (in_last[gnt_idx]) begin
          lock_q <= 1'b0;
          ptr_q  <= ptr_d;
        end else begin
          lock_q     <= 1'b1;
          lock_idx_q <= gnt_idx;
        end
`else
        ptr_q       <= ptr_d;
`endif
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef ARB_MUX_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: an N=4/WIDTH=32 instance and an N=3/WIDTH=8 instance.
// Packet-lock vectors run only when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_ready;
`ifdef ARB_MUX_LOCK_EN
  logic [3:0]   in_last;
  logic         out_last;
`endif

  logic         r3_rst_n;
  logic [2:0]   r3_in_valid;
  logic [23:0]  r3_in_data;
  logic [2:0]   r3_in_ready;
  logic         r3_out_valid;
  logic [7:0]   r3_out_data;
  logic [1:0]   r3_out_sel;
  logic         r3_out_ready;

  int checks;
  int errors;

  arb_mux #(.WIDTH(32), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(8), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (r3_rst_n),
    .in_valid  (r3_in_valid),
    .in_data   (r3_in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_last   (3'b111),
    .out_last  (),
`endif
    .in_ready  (r3_in_ready),
    .out_valid (r3_out_valid),
    .out_data  (r3_out_data),
    .out_sel   (r3_out_sel),
    .out_ready (r3_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [1:0] sel, input logic [31:0] data);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sel"},   32'(out_sel),   32'(sel));
    check({tag, "_data"},  out_data,       data);
  endtask

  int rr4 [5] = '{0, 1, 2, 3, 0};
  int rr3 [7] = '{0, 1, 2, 0, 1, 2, 0};

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    in_valid     = 4'b1111;
    out_ready    = 1'b1;
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'hA0 + k;
`ifdef ARB_MUX_LOCK_EN
    in_last      = 4'b1111;
`endif
    r3_rst_n     = 1'b0;
    r3_in_valid  = 3'b111;
    r3_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) r3_in_data[k*8 +: 8] = 8'h30 + 8'(k);

    // Reset state, with inputs active
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sel",   32'(out_sel),   32'd0);
    check("rst_data",  out_data,       32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);

    // All channels valid, sink always ready: 0,1,2,3,0 back to back
    rst_n = 1'b1;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_beat($sformatf("rr4_%0d", i), 2'(rr4[i]), 32'hA0 + 32'(rr4[i]));
    end

    // No requests: no in_ready, slot drains
    in_valid = 4'b0000;
    #1;
    check("idle_ready", 32'(in_ready), 32'd0);
    step();
    check("idle_valid", 32'(out_valid), 32'd0);

    // Single request with back-pressure: beat held, no further grants
    in_valid = 4'b0100;
    in_data[2*32 +: 32] = 32'hDEADBEEF;
    out_ready = 1'b0;
    #1;
    check("bp_ready_pre", 32'(in_ready), 32'b0100);
    step();
    in_data[2*32 +: 32] = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      expect_beat($sformatf("bp_hold_%0d", i), 2'd2, 32'hDEADBEEF);
      check($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
      step();
    end

    // Pointer now 3: channel 3 first, then wrap to 0, leaving pointer at 1
    in_valid = 4'b1001;
    in_data[3*32 +: 32] = 32'h33333333;
    out_ready = 1'b1;
    #1;
    check("wrap_ready3", 32'(in_ready), 32'b1000);
    step();
    expect_beat("wrap_ch3", 2'd3, 32'h33333333);
    check("wrap_ready0", 32'(in_ready), 32'b0001);
    step();
    expect_beat("wrap_ch0", 2'd0, 32'hA0);
    in_valid = 4'b0011;
    #1;
    check("ptr1_ready", 32'(in_ready), 32'b0010);
    step();
    expect_beat("ptr1_ch1", 2'd1, 32'hA1);

    // Reset while a beat is held
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sel",   32'(out_sel),   32'd0);
    check("mid_rst_data",  out_data,       32'd0);
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("mid_rst_ptr", 32'(in_ready), 32'b0001);
    step();
    expect_beat("post_rst", 2'd0, 32'hA0);

`ifdef ARB_MUX_LOCK_EN
    // Pointer is 1; channel 1 sends a 3-beat packet while 0 and 2 also request
    in_valid = 4'b0111;
    in_last  = 4'b1101;
    step();
    expect_beat("lock_b0", 2'd1, 32'hA1);
    check("lock_b0_last", 32'(out_last), 32'd0);
    check("lock_ready",   32'(in_ready), 32'b0010);
    step();
    expect_beat("lock_b1", 2'd1, 32'hA1);
    in_last = 4'b1111;
    step();
    expect_beat("lock_b2", 2'd1, 32'hA1);
    check("lock_b2_last", 32'(out_last), 32'd1);
    step();
    expect_beat("lock_next", 2'd2, 32'hA2);
`endif

    // N=3: pointer wraps from 2 to 0, never reaches 3
    in_valid = 4'b0000;
    r3_rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("rr3_valid_%0d", i), 32'(r3_out_valid), 32'd1);
      check($sformatf("rr3_sel_%0d", i),   32'(r3_out_sel),   32'(rr3[i]));
      check($sformatf("rr3_data_%0d", i),  32'(r3_out_data),  32'h30 + 32'(rr3[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
